ch0re_fetch: RTL and testbench
==============================

# ch0re_fetch

Instruction-fetch stage of the ch0re RV64 pipeline, directly upstream of the decoder. Holds the PC, issues one 32-bit fetch at a time on a request/grant/response instruction-memory port, and buffers returned words in a small FIFO. Presents {instruction, PC} to decode with a valid/stall handshake. Flushes and restarts on a branch/jump redirect from execute.

## Interface
- RESET_PC, 64'h0, first fetch address after reset.
- IBUF_DEPTH, 2, instruction buffer entries; power of two, at least 2.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- o_imem_req  out  1  fetch request.
- o_imem_addr  out  64  fetch address, word-aligned when requesting.
- i_imem_gnt  in  1  request accepted this cycle.
- i_imem_rvalid  in  1  response valid; at most one per accepted request, at least 1 cycle after gnt.
- i_imem_rdata  in  32  response instruction word.
- i_redirect  in  1  flush and restart from i_redirect_pc.
- i_redirect_pc  in  64  redirect target.
- i_stall  in  1  decoder cannot accept the head entry this cycle.
- o_valid  out  1  buffer head valid.
- o_instr  out  32  head instruction (decoder i_instr).
- o_pc  out  64  head PC.
- o_misaligned  out  1  head entry is an instruction-address-misaligned fault.

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_DROP, S_HALT. Reset: S_IDLE, pc = RESET_PC, buffer empty.
- Room = count + (state == S_WAIT) < IBUF_DEPTH.
- S_IDLE: with room and pc[1:0] == 0, go to S_REQ. With room and pc[1:0] != 0, push {instr 0, pc, misaligned 1} and go to S_HALT.
- S_REQ: o_imem_req = 1, o_imem_addr = pc. On gnt: req_pc <= pc, pc <= pc + 4 (64-bit wrap), go to S_WAIT.
- S_WAIT: on rvalid, push {rdata, req_pc, 0}. Then go to S_REQ if room remains after the push and pop, else S_IDLE.
- S_DROP: waits for the response of a killed request. On rvalid, discard the data and go to S_IDLE.
- S_HALT: no requests until a redirect.
- Redirect (highest priority, any state): buffer flushed, pc <= i_redirect_pc.
  - Next state is S_DROP if a request is in flight and its response has not arrived. This covers S_WAIT without rvalid, S_REQ with gnt in the same cycle, and S_DROP without rvalid.
  - Otherwise next state is S_IDLE. A same-cycle response is discarded.
  - In S_REQ without gnt, the request is withdrawn. Withdrawal on redirect is the only case where o_imem_req may drop, or o_imem_addr change, while req is high without gnt.
- Pop when o_valid && !i_stall; a pop in a redirect cycle is irrelevant because of the flush.
- Push and pop in the same cycle leave count unchanged. A push never occurs while full; room accounting guarantees this.
- Empty buffer: o_valid = 0, o_instr = 0, o_pc = 0, o_misaligned = 0.
- Ordering: o_imem_addr = pc in every state; o_pc order equals fetch order.

## Timing
- During reset and the first cycle after release: o_imem_req 0, o_imem_addr RESET_PC, o_valid 0, o_instr 0, o_pc 0, o_misaligned 0.
- First o_imem_req: 2nd cycle after rst_n rises (S_IDLE → S_REQ).
- Response to decode: rvalid in cycle N gives o_valid with that word in N+1. No bypass.
- Redirect in cycle N: o_valid = 0 in N+1. Earliest new request in N+2 (S_IDLE → S_REQ), or after the dropped response arrives.
- Throughput: one outstanding request at a time. With zero-wait gnt and 1-cycle rvalid, one instruction every 2 cycles.
- Reset asserted mid-operation: all state returns to reset values on that edge; a pending memory response after reset is ignored because the state is S_IDLE.

## Test plan
- Reset release, gnt same cycle as req, rvalid 1 cycle later, rdata 32'h00300093 → addr 0x0 requested in cycle 2. o_valid=1 with o_instr=32'h00300093, o_pc=0x0 one cycle after rvalid; next request addr 0x4.
- i_stall held high with memory always ready → exactly IBUF_DEPTH entries (PCs 0x0, 0x4) buffered, then req stays low. Releasing stall drains in order, then fetching resumes at 0x8.
- Redirect to 0x100 while in S_WAIT, rvalid 3 cycles later with 32'hDEADBEEF → that word never appears. Next request addr 0x100; first valid o_pc = 0x100.
- Redirect to 0x200 in S_REQ with gnt low → req drops next cycle and no drop wait occurs. Request to 0x200 two cycles after the redirect.
- Redirect to 0x102 → one entry {o_instr 0, o_pc 0x102, o_misaligned 1} and no further requests. A following redirect to 0x300 resumes fetching at 0x300.
- rst_n low for one cycle while S_WAIT, then rvalid → all outputs at reset values, response ignored, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/ch0re_fetch_if.sv
// ch0re fetch-stage port bundle: imem request/grant/response, redirect,
// and the {instr, pc} valid/stall handshake toward decode.
interface ch0re_fetch_if;
  logic        o_imem_req;
  logic [63:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic        i_redirect;
  logic [63:0] i_redirect_pc;
  logic        i_stall;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [63:0] o_pc;
  logic        o_misaligned;

  modport master (
    output o_imem_req, o_imem_addr,
    output o_valid, o_instr, o_pc, o_misaligned,
    input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    input  i_redirect, i_redirect_pc, i_stall
  );

  modport slave (
    input  o_imem_req, o_imem_addr,
    input  o_valid, o_instr, o_pc, o_misaligned,
    output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
    output i_redirect, i_redirect_pc, i_stall
  );
endinterface

// File: rtl/ch0re_fetch.sv
// ch0re instruction fetch: PC, one outstanding imem fetch, small FIFO to decode.
// Ports: clk, rst_n (sync, active low), bus (ch0re_fetch_if.master).
module ch0re_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IBUF_DEPTH = 2
) (
  input logic          clk,
  input logic          rst_n,
  ch0re_fetch_if.master bus
);

  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_DROP, S_HALT
  } state_t;

  state_t        st, st_nx;
  logic [63:0]   pc, pc_nx;
  logic [63:0]   req_pc, req_pc_nx;
  logic [CW-1:0] count;
  logic [CW-1:0] after;
  logic [AW-1:0] wr_ptr, rd_ptr;

  logic [31:0]   q_instr [IBUF_DEPTH];
  logic [63:0]   q_pc    [IBUF_DEPTH];
  logic          q_mis   [IBUF_DEPTH];

  logic          push, pop, flush;
  logic          room, empty, inflight;
  logic [31:0]   push_instr;
  logic [63:0]   push_pc;
  logic          push_mis;
  logic          req;

  assign empty = (count == '0);
  assign pop   = !empty && !bus.i_stall;

  // An in-flight fetch already owns a buffer slot.
  assign room = (count + CW'(st == S_WAIT)) < CW'(IBUF_DEPTH);

  // Occupancy once this cycle's response lands and head drains.
  assign after = count + CW'(1) - CW'(pop);

  assign inflight =
    (st == S_WAIT && !bus.i_imem_rvalid) ||
    (st == S_REQ  &&  bus.i_imem_gnt)    ||
    (st == S_DROP && !bus.i_imem_rvalid);

  always_comb begin
    st_nx      = st;
    pc_nx      = pc;
    req_pc_nx  = req_pc;
    push       = 1'b0;
    push_instr = '0;
    push_pc    = '0;
    push_mis   = 1'b0;
    flush      = 1'b0;
    req        = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (room) begin
          if (pc[1:0] == 2'b00) begin
            st_nx = S_REQ;
          end else begin
            push     = 1'b1;
            push_pc  = pc;
            push_mis = 1'b1;
            st_nx    = S_HALT;
          end
        end
      end
      S_REQ: begin
        req = 1'b1;
        if (bus.i_imem_gnt) begin
          req_pc_nx = pc;
          pc_nx     = pc + 64'd4;
          st_nx     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_imem_rvalid) begin
          push       = 1'b1;
          push_instr = bus.i_imem_rdata;
          push_pc    = req_pc;
          st_nx = (after < CW'(IBUF_DEPTH)) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (bus.i_imem_rvalid) st_nx = S_IDLE;
      end
      S_HALT: begin
        st_nx = S_HALT;
      end
      default: st_nx = S_IDLE;
    endcase
    if (bus.i_redirect) begin
      flush = 1'b1;
      push  = 1'b0;
      pc_nx = bus.i_redirect_pc;
      st_nx = inflight ? S_DROP : S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      st     <= st_nx;
      pc     <= pc_nx;
      req_pc <= req_pc_nx;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset; outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      q_instr[wr_ptr] <= push_instr;
      q_pc[wr_ptr]    <= push_pc;
      q_mis[wr_ptr]   <= push_mis;
    end
  end

  assign bus.o_imem_req   = req;
  assign bus.o_imem_addr  = pc;
  assign bus.o_valid      = !empty;
  assign bus.o_instr      = empty ? 32'h0 : q_instr[rd_ptr];
  assign bus.o_pc         = empty ? 64'h0 : q_pc[rd_ptr];
  assign bus.o_misaligned = empty ? 1'b0  : q_mis[rd_ptr];

endmodule

// File: tb/tb_ch0re_fetch.sv
// Directed bench for ch0re_fetch: reset, fetch flow, stall, redirects,
// misaligned halt and mid-flight reset.
module tb_ch0re_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ch0re_fetch_if bus();

  ch0re_fetch #(
    .RESET_PC  (64'h0),
    .IBUF_DEPTH(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b0;
    bus.i_imem_rdata  = 32'h0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = 64'h0;
    bus.i_stall       = 1'b0;
  endtask

  // Leaves the bench in the first cycle after rst_n rises.
  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr} !== {1'b0, 64'h0}) begin
      errors++;
      $display("FAIL reset_req req=%b addr=%h want 0/0",
               bus.o_imem_req, bus.o_imem_addr);
    end
    checks++;
    if ({bus.o_valid, bus.o_instr, bus.o_pc, bus.o_misaligned}
        !== {1'b0, 32'h0, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_head v=%b i=%h pc=%h m=%b want all 0",
               bus.o_valid, bus.o_instr, bus.o_pc, bus.o_misaligned);
    end
    rst_n = 1'b1;
    checks++;
    if ({bus.o_imem_req, bus.o_valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_c1 req=%b v=%b want 0/0",
               bus.o_imem_req, bus.o_valid);
    end
  endtask

  task automatic test_basic();
    do_reset();
    cyc();
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr} !== {1'b1, 64'h0}) begin
      errors++;
      $display("FAIL basic_req0 req=%b addr=%h want 1/0",
               bus.o_imem_req, bus.o_imem_addr);
    end
    bus.i_imem_gnt = 1'b1;
    cyc();
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = 32'h00300093;
    checks++;
    if ({bus.o_imem_req, bus.o_valid} !== 2'b00) begin
      errors++;
      $display("FAIL basic_wait req=%b v=%b want 0/0",
               bus.o_imem_req, bus.o_valid);
    end
    cyc();
    bus.i_imem_rvalid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_instr, bus.o_pc, bus.o_misaligned}
        !== {1'b1, 32'h00300093, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL basic_head0 v=%b i=%h pc=%h m=%b want 1/00300093/0/0",
               bus.o_valid, bus.o_instr, bus.o_pc, bus.o_misaligned);
    end
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr} !== {1'b1, 64'h4}) begin
      errors++;
      $display("FAIL basic_req1 req=%b addr=%h want 1/4",
               bus.o_imem_req, bus.o_imem_addr);
    end
    bus.i_imem_gnt = 1'b1;
    cyc();
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = 32'h00500113;
    checks++;
    if (bus.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_popped v=%b want 0", bus.o_valid);
    end
    cyc();
    bus.i_imem_rvalid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_instr, bus.o_pc}
        !== {1'b1, 32'h00500113, 64'h4}) begin
      errors++;
      $display("FAIL basic_head1 v=%b i=%h pc=%h want 1/00500113/4",
               bus.o_valid, bus.o_instr, bus.o_pc);
    end
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr} !== {1'b1, 64'h8}) begin
      errors++;
      $display("FAIL basic_req2 req=%b addr=%h want 1/8",
               bus.o_imem_req, bus.o_imem_addr);
    end
  endtask

  task automatic test_stall();
    do_reset();
    bus.i_stall = 1'b1;
    cyc();
    bus.i_imem_gnt = 1'b1;
    cyc();
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = 32'hA0A0A0A0;
    cyc();
    bus.i_imem_rvalid = 1'b0;
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr, bus.o_valid}
        !== {1'b1, 64'h4, 1'b1}) begin
      errors++;
      $display("FAIL stall_req1 req=%b addr=%h v=%b want 1/4/1",
               bus.o_imem_req, bus.o_imem_addr, bus.o_valid);
    end
    bus.i_imem_gnt = 1'b1;
    cyc();
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = 32'hA1A1A1A1;
    cyc();
    bus.i_imem_rvalid = 1'b0;
    checks++;
    if (bus.o_imem_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_full_req req=%b want 0", bus.o_imem_req);
    end
    cyc();
    checks++;
    if ({bus.o_imem_req, bus.o_valid, bus.o_instr, bus.o_pc}
        !== {1'b0, 1'b1, 32'hA0A0A0A0, 64'h0}) begin
      errors++;
      $display("FAIL stall_hold req=%b v=%b i=%h pc=%h want 0/1/a0a0a0a0/0",
               bus.o_imem_req, bus.o_valid, bus.o_instr, bus.o_pc);
    end
    bus.i_stall = 1'b0;
    cyc();
    checks++;
    if ({bus.o_imem_req, bus.o_valid, bus.o_instr, bus.o_pc}
        !== {1'b0, 1'b1, 32'hA1A1A1A1, 64'h4}) begin
      errors++;
      $display("FAIL stall_drain req=%b v=%b i=%h pc=%h want 0/1/a1a1a1a1/4",
               bus.o_imem_req, bus.o_valid, bus.o_instr, bus.o_pc);
    end
    cyc();
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr, bus.o_valid}
        !== {1'b1, 64'h8, 1'b0}) begin
      errors++;
      $display("FAIL stall_resume req=%b addr=%h v=%b want 1/8/0",
               bus.o_imem_req, bus.o_imem_addr, bus.o_valid);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    cyc();
    bus.i_imem_gnt = 1'b1;
    cyc();
    bus.i_imem_gnt    = 1'b0;
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 64'h100;
    cyc();
    bus.i_redirect = 1'b0;
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr, bus.o_valid}
        !== {1'b0, 64'h100, 1'b0}) begin
      errors++;
      $display("FAIL rdw_drop req=%b addr=%h v=%b want 0/100/0",
               bus.o_imem_req, bus.o_imem_addr, bus.o_valid);
    end
    cyc();
    cyc();
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = 32'hDEADBEEF;
    checks++;
    if (bus.o_imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rdw_still_drop req=%b want 0", bus.o_imem_req);
    end
    cyc();
    bus.i_imem_rvalid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_imem_req} !== 2'b00) begin
      errors++;
      $display("FAIL rdw_discard v=%b i=%h req=%b want 0/-/0",
               bus.o_valid, bus.o_instr, bus.o_imem_req);
    end
    cyc();
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr} !== {1'b1, 64'h100}) begin
      errors++;
      $display("FAIL rdw_req req=%b addr=%h want 1/100",
               bus.o_imem_req, bus.o_imem_addr);
    end
    bus.i_imem_gnt = 1'b1;
    cyc();
    bus.i_imem_gnt    = 1'b0;
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = 32'h11111111;
    cyc();
    bus.i_imem_rvalid = 1'b0;
    checks++;
    if ({bus.o_valid, bus.o_instr, bus.o_pc}
        !== {1'b1, 32'h11111111, 64'h100}) begin
      errors++;
      $display("FAIL rdw_head v=%b i=%h pc=%h want 1/11111111/100",
               bus.o_valid, bus.o_instr, bus.o_pc);
    end
  endtask

  task automatic test_redirect_req();
    do_reset();
    cyc();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 64'h200;
    cyc();
    bus.i_redirect = 1'b0;
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr} !== {1'b0, 64'h200}) begin
      errors++;
      $display("FAIL rdr_withdraw req=%b addr=%h want 0/200",
               bus.o_imem_req, bus.o_imem_addr);
    end
    cyc();
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr} !== {1'b1, 64'h200}) begin
      errors++;
      $display("FAIL rdr_req req=%b addr=%h want 1/200",
               bus.o_imem_req, bus.o_imem_addr);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 64'h102;
    cyc();
    bus.i_redirect = 1'b0;
    cyc();
    checks++;
    if ({bus.o_valid, bus.o_instr, bus.o_pc, bus.o_misaligned}
        !== {1'b1, 32'h0, 64'h102, 1'b1}) begin
      errors++;
      $display("FAIL mis_head v=%b i=%h pc=%h m=%b want 1/0/102/1",
               bus.o_valid, bus.o_instr, bus.o_pc, bus.o_misaligned);
    end
    checks++;
    if (bus.o_imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_noreq req=%b want 0", bus.o_imem_req);
    end
    cyc();
    cyc();
    checks++;
    if ({bus.o_imem_req, bus.o_valid} !== 2'b00) begin
      errors++;
      $display("FAIL mis_halt req=%b v=%b want 0/0",
               bus.o_imem_req, bus.o_valid);
    end
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 64'h300;
    cyc();
    bus.i_redirect = 1'b0;
    cyc();
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr} !== {1'b1, 64'h300}) begin
      errors++;
      $display("FAIL mis_resume req=%b addr=%h want 1/300",
               bus.o_imem_req, bus.o_imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc();
    bus.i_imem_gnt = 1'b1;
    cyc();
    bus.i_imem_gnt = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    bus.i_imem_rvalid = 1'b1;
    bus.i_imem_rdata  = 32'hCAFEF00D;
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr, bus.o_valid}
        !== {1'b0, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_reset req=%b addr=%h v=%b want 0/0/0",
               bus.o_imem_req, bus.o_imem_addr, bus.o_valid);
    end
    cyc();
    bus.i_imem_rvalid = 1'b0;
    checks++;
    if ({bus.o_imem_req, bus.o_imem_addr, bus.o_valid}
        !== {1'b1, 64'h0, 1'b0}) begin
      errors++;
      $display("FAIL rmid_restart req=%b addr=%h v=%b want 1/0/0",
               bus.o_imem_req, bus.o_imem_addr, bus.o_valid);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_misaligned();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
